qsort_range_ctrl: RTL and testbench

- Quicksort sequencer: the initiator that drives the Lomuto partition engine.
- Holds a LIFO stack of pending (lo,hi) subranges and issues one partition request per range.
- Consumes the pivot index returned by the engine, then pushes the resulting left/right subranges.
- Sits between the host start/done interface and the partition engine; it never touches array data itself.

---
 rtl/qsort_range_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_qsort_range_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsort_range_ctrl.sv
// Quicksort range sequencer: keeps a LIFO of pending (lo,hi) subranges and
// hands them one at a time to a partition engine, pushing the two halves back.
module qsort_range_ctrl #(
  parameter int IDX_W       = 3,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] lo_in,
  input  logic [IDX_W-1:0] hi_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             part_req,
  output logic [IDX_W-1:0] part_lo,
  output logic [IDX_W-1:0] part_hi,
  input  logic             part_ack,
  input  logic [IDX_W-1:0] part_pivot_idx,
  output logic [CNT_W-1:0] part_cnt
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]  ONE_SP  = SP_W'(1);
  localparam logic [IDX_W:0]   ONE_X   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, INIT, POP, ISSUE, WAIT, PUSH_R, PUSH_L, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [SP_W-1:0]  sp_q, sp_d, top_idx;
  logic [IDX_W-1:0] range_lo_q, range_lo_d, range_hi_q, range_hi_d;
  logic [IDX_W-1:0] part_lo_q, part_lo_d, part_hi_q, part_hi_d;
  logic [IDX_W-1:0] pivot_q, pivot_d;
  logic             part_req_q, part_req_d;
  logic [CNT_W-1:0] part_cnt_q, part_cnt_d;
  logic             err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic             push_en, push_ok;
  logic [IDX_W-1:0] push_lo, push_hi;
  logic [IDX_W-1:0] stk_lo_q [2**SP_W];
  logic [IDX_W-1:0] stk_hi_q [2**SP_W];

  // One extra bit so p+1 at the top index and p-1 at zero cannot wrap.
  logic [IDX_W:0] lo_x, hi_x, p_x, ack_x;
  assign lo_x  = {1'b0, part_lo_q};
  assign hi_x  = {1'b0, part_hi_q};
  assign p_x   = {1'b0, pivot_q};
  assign ack_x = {1'b0, part_pivot_idx};

  assign top_idx = sp_q - ONE_SP;
  assign push_ok = push_en && (sp_q != SP_FULL);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    range_lo_d = range_lo_q;
    range_hi_d = range_hi_q;
    part_lo_d  = part_lo_q;
    part_hi_d  = part_hi_q;
    pivot_d    = pivot_q;
    part_req_d = part_req_q;
    part_cnt_d = part_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    push_en    = 1'b0;
    push_lo    = '0;
    push_hi    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          range_lo_d = lo_in;
          range_hi_d = hi_in;
          err_d      = 1'b0;
          part_cnt_d = '0;
          state_d    = INIT;
        end
      end
      INIT: begin
        if (range_lo_q < range_hi_q) begin
          push_en = 1'b1;
          push_lo = range_lo_q;
          push_hi = range_hi_q;
        end
        state_d = POP;
      end
      POP: begin
        if (sp_q == '0) begin
          state_d = FIN;
        end else begin
          part_lo_d = stk_lo_q[top_idx];
          part_hi_d = stk_hi_q[top_idx];
          sp_d      = top_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        part_req_d = 1'b1;
        if (part_cnt_q != '1) part_cnt_d = part_cnt_q + ONE_C;
        state_d = WAIT;
      end
      WAIT: begin
        if (part_ack) begin
          part_req_d = 1'b0;
          pivot_d    = part_pivot_idx;
          if (ack_x < lo_x || ack_x > hi_x) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = PUSH_R;
          end
        end
      end
      PUSH_R: begin
        if ((p_x + ONE_X) < hi_x) begin
          push_en = 1'b1;
          push_lo = pivot_q + ONE_I;
          push_hi = part_hi_q;
        end
        state_d = PUSH_L;
      end
      PUSH_L: begin
        if (p_x > (lo_x + ONE_X)) begin
          push_en = 1'b1;
          push_lo = part_lo_q;
          push_hi = pivot_q - ONE_I;
        end
        state_d = POP;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A push into a full stack aborts the sort instead of losing a range silently.
    if (push_en) begin
      if (sp_q == SP_FULL) begin
        err_d   = 1'b1;
        state_d = FIN;
      end else begin
        sp_d = sp_q + ONE_SP;
      end
    end

    busy_d = !(state_d == IDLE || state_d == FIN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      range_lo_q <= '0;
      range_hi_q <= '0;
      part_lo_q  <= '0;
      part_hi_q  <= '0;
      pivot_q    <= '0;
      part_req_q <= 1'b0;
      part_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      range_lo_q <= range_lo_d;
      range_hi_q <= range_hi_d;
      part_lo_q  <= part_lo_d;
      part_hi_q  <= part_hi_d;
      pivot_q    <= pivot_d;
      part_req_q <= part_req_d;
      part_cnt_q <= part_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push_ok) begin
      stk_lo_q[sp_q] <= push_lo;
      stk_hi_q[sp_q] <= push_hi;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign part_req = part_req_q;
  assign part_lo  = part_lo_q;
  assign part_hi  = part_hi_q;
  assign part_cnt = part_cnt_q;

endmodule

// File: tb/tb_qsort_range_ctrl.sv
// Bench for qsort_range_ctrl: an engine model answers requests while a queue-based
// quicksort reference predicts request order, latencies, part_cnt and err.
module tb_qsort_range_ctrl;

  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             sel   = 1'b0;
  logic [IDX_W-1:0] lo_in = '0, hi_in = '0, part_pivot_idx = '0;
  logic             part_ack = 1'b0;
  logic             start_a, start_b;

  logic             a_busy, a_done, a_err, a_req, b_busy, b_done, b_err, b_req;
  logic [IDX_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  logic             obs_busy, obs_done, obs_err, obs_req;
  logic [IDX_W-1:0] obs_lo, obs_hi;
  logic [CNT_W-1:0] obs_cnt;

  int vectors = 0;
  int miscompares = 0;

  int m_lo[$], m_hi[$];
  int m_err, m_cnt, m_depth, m_lat;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  qsort_range_ctrl #(.IDX_W(IDX_W), .STACK_DEPTH(8), .CNT_W(CNT_W)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .lo_in(lo_in), .hi_in(hi_in),
    .busy(a_busy), .done(a_done), .err(a_err), .part_req(a_req),
    .part_lo(a_lo), .part_hi(a_hi), .part_ack(part_ack),
    .part_pivot_idx(part_pivot_idx), .part_cnt(a_cnt));

  // Shallow-stack instance used only to provoke stack overflow.
  qsort_range_ctrl #(.IDX_W(IDX_W), .STACK_DEPTH(1), .CNT_W(CNT_W)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .lo_in(lo_in), .hi_in(hi_in),
    .busy(b_busy), .done(b_done), .err(b_err), .part_req(b_req),
    .part_lo(b_lo), .part_hi(b_hi), .part_ack(part_ack),
    .part_pivot_idx(part_pivot_idx), .part_cnt(b_cnt));

  always #5 clock = ~clock;

  always_comb begin
    obs_busy = sel ? b_busy : a_busy;
    obs_done = sel ? b_done : a_done;
    obs_err  = sel ? b_err  : a_err;
    obs_req  = sel ? b_req  : a_req;
    obs_lo   = sel ? b_lo   : a_lo;
    obs_hi   = sel ? b_hi   : a_hi;
    obs_cnt  = sel ? b_cnt  : a_cnt;
  end

  function automatic int model_push(int l, int h);
    if (m_lo.size() >= m_depth) begin
      m_err = 1;
      return 0;
    end
    m_lo.push_back(l);
    m_hi.push_back(h);
    return 1;
  endfunction

  function automatic int pick_pivot(int mode, int l, int h, int first);
    case (mode)
      0:       return l;
      1:       return (l + h) >> 1;
      2:       return int'($urandom_range(h, l));
      3:       return first ? h + 1 : l;
      default: return int'($urandom_range(7, 0));
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; start = 1'b0; part_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Runs one sort with an engine model; mode selects the pivot rule, noise
  // injects a stray ack and start while the sequencer is busy pushing.
  task automatic run_sort(input int lo, input int hi, input int mode, input int noise,
                          input string name);
    int n, p, l, h, first, fin, after_ack, delay;
    m_lo.delete(); m_hi.delete();
    m_err = 0; m_cnt = 0; m_depth = sel ? 1 : 8;
    if (lo < hi) void'(model_push(lo, hi));
    @(negedge clock);
    start = 1'b1; lo_in = lo[IDX_W-1:0]; hi_in = hi[IDX_W-1:0];
    @(negedge clock);
    start = 1'b0;
    m_lat = 3; first = 1; fin = 0; after_ack = 0;
    while (!fin) begin
      n = 0;
      while (!obs_req && !obs_done && n < 40) begin
        if (!m_err && n < m_lat - 1) begin
          vectors++;
          if (obs_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s busy n=%0d: got %b expected 1", name, n, obs_busy);
          end
        end
        if (noise != 0 && after_ack != 0 && n == 0) begin
          part_ack = 1'b1; part_pivot_idx = '0;
          start = 1'b1; lo_in = 3'd2; hi_in = 3'd6;
        end
        @(negedge clock);
        n++;
        part_ack = 1'b0; start = 1'b0;
        lo_in = lo[IDX_W-1:0]; hi_in = hi[IDX_W-1:0];
      end
      vectors++;
      if (n >= 40) begin
        miscompares++;
        $display("[TB] FAIL %s timeout: got no req/done after %0d cycles, expected %0d", name, n, m_lat);
        fin = 1;
      end else if (n != m_lat) begin
        miscompares++;
        $display("[TB] FAIL %s latency: got %0d cycles expected %0d", name, n, m_lat);
      end
      if (fin) begin
      end else if (obs_done) begin
        vectors += 4;
        if (!(m_err != 0 || m_lo.size() == 0)) begin
          miscompares++;
          $display("[TB] FAIL %s early done: got done with %0d ranges pending expected 0", name, m_lo.size());
        end
        if (obs_err !== m_err[0]) begin
          miscompares++;
          $display("[TB] FAIL %s err: got %b expected %0d", name, obs_err, m_err);
        end
        if (obs_cnt !== CNT_W'(m_cnt)) begin
          miscompares++;
          $display("[TB] FAIL %s part_cnt: got %0d expected %0d", name, obs_cnt, m_cnt);
        end
        if (obs_busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL %s busy at done: got %b expected 0", name, obs_busy);
        end
        @(negedge clock);
        if (obs_done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL %s done width: got %b expected 0", name, obs_done);
        end
        fin = 1;
      end else begin
        vectors++;
        if (m_err != 0 || m_lo.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL %s extra request: got (%0d,%0d) expected none", name, obs_lo, obs_hi);
          fin = 1;
        end else begin
          l = m_lo.pop_back();
          h = m_hi.pop_back();
          m_cnt++;
          if (obs_lo !== IDX_W'(l) || obs_hi !== IDX_W'(h) || obs_cnt !== CNT_W'(m_cnt)) begin
            miscompares++;
            $display("[TB] FAIL %s request: got (%0d,%0d) cnt %0d expected (%0d,%0d) cnt %0d",
                     name, obs_lo, obs_hi, obs_cnt, l, h, m_cnt);
          end
          p = pick_pivot(mode, l, h, first);
          first = 0;
          delay = int'($urandom_range(3, 0));
          repeat (delay) begin
            @(negedge clock);
            vectors++;
            if (obs_req !== 1'b1 || obs_lo !== IDX_W'(l) || obs_hi !== IDX_W'(h)) begin
              miscompares++;
              $display("[TB] FAIL %s hold: got req %b (%0d,%0d) expected 1 (%0d,%0d)",
                       name, obs_req, obs_lo, obs_hi, l, h);
            end
          end
          part_ack = 1'b1; part_pivot_idx = p[IDX_W-1:0];
          @(negedge clock);
          part_ack = 1'b0; part_pivot_idx = IDX_W'($urandom);
          vectors++;
          if (obs_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s req drop: got %b expected 0", name, obs_req);
          end
          if (p < l || p > h) begin
            m_err = 1; m_lat = 1;
          end else begin
            m_lat = 4;
            if (p + 1 < h && model_push(p + 1, h) == 0) m_lat = 2;
            if (m_err == 0 && p > l + 1 && model_push(l, p - 1) == 0) m_lat = 3;
          end
          after_ack = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({a_busy, a_done, a_err, a_req, a_lo, a_hi, a_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: got busy%b done%b err%b req%b lo%0d hi%0d cnt%0d expected all 0",
               a_busy, a_done, a_err, a_req, a_lo, a_hi, a_cnt);
    end
  endtask

  task automatic test_linear();
    apply_reset();
    run_sort(0, 7, 0, 0, "linear");
  endtask

  task automatic test_midpoint();
    apply_reset();
    run_sort(0, 7, 1, 0, "midpoint");
  endtask

  task automatic test_single();
    apply_reset();
    run_sort(3, 3, 0, 0, "single");
    run_sort(7, 7, 0, 0, "single_top");
  endtask

  task automatic test_bad_pivot();
    apply_reset();
    run_sort(0, 5, 3, 0, "bad_pivot");
    run_sort(0, 1, 0, 0, "err_clear");
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    apply_reset();
    run_sort(0, 7, 1, 0, "overflow");
    sel = 1'b0;
    apply_reset();
  endtask

  task automatic test_abort_and_ignore();
    int n;
    apply_reset();
    @(negedge clock);
    start = 1'b1; lo_in = 3'd0; hi_in = 3'd7;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!a_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (a_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort setup: got req %b expected 1", a_req);
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    vectors++;
    if ({a_busy, a_done, a_err, a_req, a_lo, a_hi, a_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL abort: got busy%b done%b err%b req%b lo%0d hi%0d cnt%0d expected all 0",
               a_busy, a_done, a_err, a_req, a_lo, a_hi, a_cnt);
    end
    run_sort(0, 7, 0, 1, "ignore_noise");
  endtask

  task automatic test_random();
    int lo, hi;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      lo = int'($urandom_range(7, 0));
      hi = int'($urandom_range(7, 0));
      run_sort(lo, hi, (i % 3 == 2) ? 4 : 2, int'($urandom_range(1, 0)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_midpoint();
    test_single();
    test_bad_pivot();
    test_overflow();
    test_abort_and_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
